// File: rtl/servant_ram_arbiter_pkg.sv
// Shared grant/state encodings for the servant RAM round-robin arbiter.
package servant_ram_arbiter_pkg;

    localparam logic [1:0] GNT_IBUS = 2'd0;
    localparam logic [1:0] GNT_DBUS = 2'd1;
    localparam logic [1:0] GNT_EXT  = 2'd2;
    localparam logic [1:0] GNT_NONE = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/servant_rr_pick.sv
// Combinational 3-way round-robin selector: first requester after last_i in order 0,1,2.
module servant_rr_pick
    import servant_ram_arbiter_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] winner_o,
    output logic       valid_o
);

    always_comb begin
        winner_o = GNT_IBUS;
        valid_o  = |req_i;
        case (last_i)
            GNT_IBUS: begin
                if (req_i[1])      winner_o = GNT_DBUS;
                else if (req_i[2]) winner_o = GNT_EXT;
                else               winner_o = GNT_IBUS;
            end
            GNT_DBUS: begin
                if (req_i[2])      winner_o = GNT_EXT;
                else if (req_i[0]) winner_o = GNT_IBUS;
                else               winner_o = GNT_DBUS;
            end
            // GNT_EXT and GNT_NONE both restart the rotation at ibus
            default: begin
                if (req_i[0])      winner_o = GNT_IBUS;
                else if (req_i[1]) winner_o = GNT_DBUS;
                else               winner_o = GNT_EXT;
            end
        endcase
    end

endmodule

// File: rtl/servant_ram_arbiter.sv
// Round-robin Wishbone arbiter sharing servant_ram between ibus, dbus and an external master.
// Optional forced-ack watchdog enabled by defining SERVANT_RAM_ARB_TIMEOUT_EN.
module servant_ram_arbiter
    import servant_ram_arbiter_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst_n,

    input  logic [AW-1:0] i_wb_ibus_adr,
    input  logic          i_wb_ibus_cyc,
    output logic [31:0]   o_wb_ibus_rdt,
    output logic          o_wb_ibus_ack,

    input  logic [AW-1:0] i_wb_dbus_adr,
    input  logic [31:0]   i_wb_dbus_dat,
    input  logic [3:0]    i_wb_dbus_sel,
    input  logic          i_wb_dbus_we,
    input  logic          i_wb_dbus_cyc,
    output logic [31:0]   o_wb_dbus_rdt,
    output logic          o_wb_dbus_ack,

    input  logic [AW-1:0] i_wb_ext_adr,
    input  logic [31:0]   i_wb_ext_dat,
    input  logic [3:0]    i_wb_ext_sel,
    input  logic          i_wb_ext_we,
    input  logic          i_wb_ext_cyc,
    output logic [31:0]   o_wb_ext_rdt,
    output logic          o_wb_ext_ack,

    output logic [AW-1:0] o_wb_mem_adr,
    output logic [31:0]   o_wb_mem_dat,
    output logic [3:0]    o_wb_mem_sel,
    output logic          o_wb_mem_we,
    output logic          o_wb_mem_cyc,
    input  logic [31:0]   i_wb_mem_rdt,
    input  logic          i_wb_mem_ack,

    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    state_e     state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic [1:0] last_q,  last_d;
    logic [1:0] pick_winner;
    logic       pick_valid;
    logic       busy;
    logic       forced;
    logic       ack_any;
    logic [31:0] rdt;

    assign busy = (state_q == BUSY);

    servant_rr_pick u_pick (
        .req_i    ({i_wb_ext_cyc, i_wb_dbus_cyc, i_wb_ibus_cyc}),
        .last_i   (last_q),
        .winner_o (pick_winner),
        .valid_o  (pick_valid)
    );

`ifdef SERVANT_RAM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    // forced ack lands on the TIMEOUT_CYCLES-th BUSY cycle with no RAM ack
    assign forced    = busy && !i_wb_mem_ack && (cnt_q == CNT_LAST);
    assign rdt       = forced ? '0 : i_wb_mem_rdt;
    assign o_timeout = timeout_q;

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (!busy) begin
            cnt_d = '0;
        end else if (!i_wb_mem_ack) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (forced) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign forced    = 1'b0;
    assign rdt       = i_wb_mem_rdt;
    assign o_timeout = 1'b0;
`endif

    assign ack_any = busy && (i_wb_mem_ack || forced);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BUSY;
                    grant_d = pick_winner;
                    last_d  = pick_winner;
                end
            end
            BUSY: begin
                if (ack_any) begin
                    state_d = IDLE;
                    grant_d = GNT_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = GNT_NONE;
            end
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q <= IDLE;
            grant_q <= GNT_NONE;
            last_q  <= GNT_EXT;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        o_wb_mem_adr = '0;
        o_wb_mem_dat = '0;
        o_wb_mem_sel = '0;
        o_wb_mem_we  = 1'b0;
        case (grant_q)
            GNT_IBUS: begin
                o_wb_mem_adr = i_wb_ibus_adr;
                o_wb_mem_sel = 4'hf;
            end
            GNT_DBUS: begin
                o_wb_mem_adr = i_wb_dbus_adr;
                o_wb_mem_dat = i_wb_dbus_dat;
                o_wb_mem_sel = i_wb_dbus_sel;
                o_wb_mem_we  = i_wb_dbus_we;
            end
            GNT_EXT: begin
                o_wb_mem_adr = i_wb_ext_adr;
                o_wb_mem_dat = i_wb_ext_dat;
                o_wb_mem_sel = i_wb_ext_sel;
                o_wb_mem_we  = i_wb_ext_we;
            end
            default: ;
        endcase
    end

    assign o_wb_mem_cyc  = busy;
    assign o_grant       = busy ? grant_q : GNT_NONE;
    assign o_wb_ibus_ack = ack_any && (grant_q == GNT_IBUS);
    assign o_wb_dbus_ack = ack_any && (grant_q == GNT_DBUS);
    assign o_wb_ext_ack  = ack_any && (grant_q == GNT_EXT);
    assign o_wb_ibus_rdt = rdt;
    assign o_wb_dbus_rdt = rdt;
    assign o_wb_ext_rdt  = rdt;

endmodule
